// File: rtl/adc_current_monitor_pkg.sv
// Shared constants for the ADC current monitor: sample width, status bit
// positions and the monitor state encoding.
package adc_current_monitor_pkg;

    localparam int ADC_BITS   = 14;

    localparam int STAT_TRIP  = 0;
    localparam int STAT_INST  = 1;
    localparam int STAT_STALE = 2;
    localparam int STAT_MODE  = 3;
    localparam int STAT_FILL  = 4;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        TRIPPED = 2'd2
    } mon_state_e;

endpackage

// File: rtl/adc_current_monitor_boxcar_avg.sv
// Running boxcar average over the last 2^AVG_LOG2 qualified samples; the
// average is only published once the window has been completely filled.
module boxcar_avg
    import adc_current_monitor_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_stb,
    input  logic [ADC_BITS-1:0] i_sample_data,
    output logic [15:0]         o_avg_data,
    output logic                o_avg_valid,
    output logic                o_fill_done
);
    localparam int WIN   = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_BITS + AVG_LOG2;
    localparam logic [AVG_LOG2:0] WIN_CNT  = (AVG_LOG2 + 1)'(WIN);
    localparam logic [AVG_LOG2:0] LAST_CNT = (AVG_LOG2 + 1)'(WIN - 1);

    logic [ADC_BITS-1:0] r_buf [WIN];
    logic [SUM_W-1:0]    r_sum;
    logic [AVG_LOG2-1:0] r_wp;
    logic [AVG_LOG2:0]   r_fill_cnt;
    logic [SUM_W-1:0]    w_sum_nxt;
    logic                w_full_before;
    logic                w_full_after;

    // Next sum replaces the oldest sample; the sum always contains it, so no underflow.
    always_comb begin
        w_sum_nxt     = r_sum + SUM_W'(i_sample_data) - SUM_W'(r_buf[r_wp]);
        w_full_before = (r_fill_cnt == WIN_CNT);
        w_full_after  = w_full_before | (r_fill_cnt == LAST_CNT);
    end

    // Window storage, running sum and published average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum       <= {SUM_W{1'b0}};
            r_wp        <= {AVG_LOG2{1'b0}};
            r_fill_cnt  <= {(AVG_LOG2 + 1){1'b0}};
            o_avg_data  <= 16'd0;
            o_avg_valid <= 1'b0;
            o_fill_done <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                r_buf[i] <= {ADC_BITS{1'b0}};
            end
        end else begin
            o_avg_valid <= 1'b0;
            if (i_sample_stb) begin
                r_sum       <= w_sum_nxt;
                r_buf[r_wp] <= i_sample_data;
                r_wp        <= r_wp + 1'b1;
                if (!w_full_before) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                // The sample that completes the window updates the average but is not strobed.
                o_avg_valid <= w_full_before;
                o_fill_done <= w_full_after;
                if (w_full_after) begin
                    o_avg_data <= 16'(w_sum_nxt >> AVG_LOG2);
                end
            end
        end
    end

endmodule

// File: rtl/adc_current_monitor.sv
// ADC current monitor: boxcar average vs. PWM/CW limit with consecutive-trip
// detection, stale-sample timer and sticky host status.
module adc_current_monitor
    import adc_current_monitor_pkg::*;
#(
    parameter int AVG_LOG2     = 2,
    parameter int TRIP_COUNT   = 3,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adc_data_valid,
    input  logic [15:0] i_adc_data,
    input  logic        i_pwm_cw_mode_select,
    input  logic [15:0] i_pwm_mon_current_limit,
    input  logic [15:0] i_cw_mon_current_limit,
    input  logic        i_mon_limit_update,
    input  logic        i_adc_status_clear,
    output logic [15:0] o_avg_data,
    output logic        o_avg_valid,
    output logic        o_fault,
    output logic [7:0]  o_monitor_status
);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [3:0]       TRIP_MAX = 4'(TRIP_COUNT);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CLKS);

    logic             r_valid_d;
    logic             r_sample_stb;
    logic [15:0]      r_sample_data;
    logic             r_mode_d;
    logic [15:0]      r_pwm_lim;
    logic [15:0]      r_cw_lim;
    logic [3:0]       r_over_cnt;
    logic [TMR_W-1:0] r_timer;
    mon_state_e       r_state;

    mon_state_e       w_state_nxt;
    logic [3:0]       w_fsm_cnt;
    logic [3:0]       w_over_cnt_nxt;
    logic [3:0]       w_over_inc;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [15:0]      w_limit;
    logic             w_edge;
    logic             w_fill_done;
    logic             w_over;
    logic             w_trip_set;
    logic             w_inst_set;
    logic             w_stale_set;

    assign w_edge      = i_adc_data_valid & ~r_valid_d;
    assign w_limit     = i_pwm_cw_mode_select ? r_cw_lim : r_pwm_lim;
    assign w_over      = (w_limit != 16'd0) && (o_avg_data > w_limit);
    assign w_inst_set  = r_sample_stb && (w_limit != 16'd0) && (r_sample_data > w_limit);
    assign w_over_inc  = (r_over_cnt == TRIP_MAX) ? r_over_cnt : r_over_cnt + 4'd1;
    assign w_timer_nxt = w_edge ? {TMR_W{1'b0}}
                       : (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
    assign w_stale_set = (w_timer_nxt == TMR_MAX);
    assign w_over_cnt_nxt = (i_pwm_cw_mode_select != r_mode_d) ? 4'd0 : w_fsm_cnt;

    // Rising-edge sample qualification and capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_d     <= 1'b0;
            r_sample_stb  <= 1'b0;
            r_sample_data <= 16'd0;
            r_mode_d      <= 1'b0;
        end else begin
            r_valid_d    <= i_adc_data_valid;
            r_sample_stb <= w_edge;
            r_mode_d     <= i_pwm_cw_mode_select;
            if (w_edge) begin
                r_sample_data <= i_adc_data;
            end
        end
    end

    // Limit shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_lim <= 16'd0;
            r_cw_lim  <= 16'd0;
        end else if (i_mon_limit_update) begin
            r_pwm_lim <= i_pwm_mon_current_limit;
            r_cw_lim  <= i_cw_mon_current_limit;
        end
    end

    boxcar_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_boxcar (
        .clk           (clk),
        .rst           (rst),
        .i_sample_stb  (r_sample_stb),
        .i_sample_data (r_sample_data[ADC_BITS-1:0]),
        .o_avg_data    (o_avg_data),
        .o_avg_valid   (o_avg_valid),
        .o_fill_done   (w_fill_done)
    );

    // Monitor state machine: next state and over-limit counter.
    always_comb begin
        w_state_nxt = r_state;
        w_fsm_cnt   = r_over_cnt;
        w_trip_set  = 1'b0;
        case (r_state)
            FILL: begin
                if (w_fill_done) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            RUN: begin
                if (o_avg_valid && w_over) begin
                    w_fsm_cnt = w_over_inc;
                    if (w_over_inc == TRIP_MAX) begin
                        w_state_nxt = TRIPPED;
                        w_trip_set  = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if (o_avg_valid) begin
                    w_fsm_cnt = 4'd0;
                end else begin
                    w_fsm_cnt = r_over_cnt;
                end
            end
            TRIPPED: begin
                if (i_adc_status_clear) begin
                    w_state_nxt = RUN;
                    w_fsm_cnt   = 4'd0;
                end else begin
                    w_state_nxt = TRIPPED;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_fsm_cnt   = 4'd0;
            end
        endcase
    end

    // State, over-count and stale timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_over_cnt <= 4'd0;
            r_timer    <= {TMR_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_over_cnt <= w_over_cnt_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    // Fault and status; a set in the same clk as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fault          <= 1'b0;
            o_monitor_status <= 8'h00;
        end else begin
            o_fault                        <= (w_state_nxt == TRIPPED);
            o_monitor_status[STAT_TRIP]    <= (w_state_nxt == TRIPPED);
            o_monitor_status[STAT_INST]    <= w_inst_set
                                            | (o_monitor_status[STAT_INST] & ~i_adc_status_clear);
            o_monitor_status[STAT_STALE]   <= w_stale_set
                                            | (o_monitor_status[STAT_STALE] & ~i_adc_status_clear);
            o_monitor_status[STAT_MODE]    <= w_trip_set ? i_pwm_cw_mode_select
                                            : (o_monitor_status[STAT_MODE] & ~i_adc_status_clear);
            o_monitor_status[STAT_FILL]    <= (w_state_nxt == FILL);
            o_monitor_status[7:5]          <= 3'b000;
        end
    end

endmodule
